// File: rtl/led_blink_pkg.sv
// Shared types and default constants for the LED blink engine.
package led_blink_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } blink_state_t;

   localparam int unsigned CLK_HZ_DEF  = 100_000_000;
   localparam int unsigned TICK_HZ_DEF = 1000;
   localparam int unsigned IW_DEF      = 16;

endpackage

// File: rtl/led_blink_timer_if.sv
// Interval request in, LED drive and status out.
interface led_blink_timer_if #(
   parameter int unsigned IW = 16
) ();

   logic [IW-1:0] interval;
   logic          led;
   logic          toggle;
   logic          busy;

   modport master (
      output interval,
      input  led,
      input  toggle,
      input  busy
   );

   modport slave (
      input  interval,
      output led,
      output toggle,
      output busy
   );

endinterface

// File: rtl/led_blink_timer_tick_gen.sv
// Millisecond timebase: free-running prescaler with a synchronous clear.
module ms_tick_gen #(
   parameter int unsigned DIV = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] pre_cnt;
   logic          at_top;

   assign at_top = (pre_cnt == CW'(DIV - 1));

   // Tick on the last count; a clear suppresses it so the new phase starts fresh.
   assign tick = at_top && !clr;

   // Prescaler counts 0..DIV-1 and wraps.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pre_cnt <= '0;
      end else if (at_top) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_blink_timer.sv
// Per-channel LED blink engine: on/off phases of `interval` ticks each.
module led_blink_timer
   import led_blink_pkg::*;
#(
   parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
   parameter int unsigned TICK_HZ = TICK_HZ_DEF,
   parameter int unsigned IW      = IW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   led_blink_timer_if.slave   bus
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;

   blink_state_t  state,     state_nxt;
   logic [IW-1:0] ms_cnt,    ms_cnt_nxt;
   logic [IW-1:0] active_iv, active_iv_nxt;
   logic          led_q,     led_nxt;
   logic          toggle_q,  toggle_nxt;
   logic          busy_q,    busy_nxt;
   logic [IW-1:0] iv_in;
   logic          clr_c;
   logic          tick;

   assign iv_in      = bus.interval;
   assign bus.led    = led_q;
   assign bus.toggle = toggle_q;
   assign bus.busy   = busy_q;

   ms_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_c),
      .tick (tick)
   );

   // Next-state and output decode; new intervals are only adopted at phase boundaries.
   always_comb begin
      state_nxt     = state;
      ms_cnt_nxt    = ms_cnt;
      active_iv_nxt = active_iv;
      led_nxt       = led_q;
      toggle_nxt    = 1'b0;
      clr_c         = 1'b0;
      unique case (state)
         ST_IDLE: begin
            led_nxt    = 1'b0;
            ms_cnt_nxt = '0;
            if (iv_in != '0) begin
               active_iv_nxt = iv_in;
               clr_c         = 1'b1;
               state_nxt     = ST_ON;
               led_nxt       = 1'b1;
               toggle_nxt    = 1'b1;
            end
         end
         ST_ON, ST_OFF: begin
            if (iv_in == '0) begin
               state_nxt  = ST_IDLE;
               ms_cnt_nxt = '0;
               led_nxt    = 1'b0;
               toggle_nxt = led_q;
            end else if (tick && (ms_cnt == active_iv - IW'(1))) begin
               ms_cnt_nxt    = '0;
               active_iv_nxt = iv_in;
               state_nxt     = (state == ST_ON) ? ST_OFF : ST_ON;
               led_nxt       = ~led_q;
               toggle_nxt    = 1'b1;
            end else if (tick) begin
               ms_cnt_nxt = ms_cnt + IW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            led_nxt   = 1'b0;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ms_cnt    <= '0;
         active_iv <= '0;
         led_q     <= 1'b0;
         toggle_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         ms_cnt    <= ms_cnt_nxt;
         active_iv <= active_iv_nxt;
         led_q     <= led_nxt;
         toggle_q  <= toggle_nxt;
         busy_q    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_led_blink_timer.sv
// Directed bench for led_blink_timer with CLK_HZ=10, TICK_HZ=1 (10 clocks per tick).
module tb_led_blink_timer;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   led_blink_timer_if #(.IW(16)) bus ();

   led_blink_timer #(
      .CLK_HZ  (10),
      .TICK_HZ (1),
      .IW      (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Advance one clock; sample and drive 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Count clocks until led leaves level lvl (bounded).
   task automatic measure(input logic lvl, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.led === lvl && n < 1000);
   endtask

   initial begin
      int n;
      int seen;

      // Reset
      rst = 1'b1;
      bus.interval = 16'd0;
      repeat (3) step();
      check("reset_led",    int'(bus.led),    0);
      check("reset_toggle", int'(bus.toggle), 0);
      check("reset_busy",   int'(bus.busy),   0);
      rst = 1'b0;

      // 1: interval 0 holds everything dark
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.led !== 1'b0 || bus.toggle !== 1'b0 || bus.busy !== 1'b0) seen++;
      end
      check("idle_hold", seen, 0);

      // 2: interval 3 -> 30/30 clocks
      bus.interval = 16'd3;
      step();
      check("start_led",    int'(bus.led),    1);
      check("start_toggle", int'(bus.toggle), 1);
      check("start_busy",   int'(bus.busy),   1);
      step();
      check("toggle_one_cycle", int'(bus.toggle), 0);
      measure(1'b1, n);
      check("on3_len", n + 1, 30);
      check("fall_toggle", int'(bus.toggle), 1);
      measure(1'b0, n);
      check("off3_len", n, 30);
      check("rise_toggle", int'(bus.toggle), 1);

      // 3: change 3 -> 5 at clock 12 of an ON phase
      repeat (12) step();
      bus.interval = 16'd5;
      measure(1'b1, n);
      check("on_keep_old_len", n, 18);
      measure(1'b0, n);
      check("off5_len", n, 50);
      measure(1'b1, n);
      check("on5_len", n, 50);

      // 4: kill mid-OFF, restart, kill mid-ON, restart with exact first phase
      repeat (7) step();
      bus.interval = 16'd0;
      step();
      check("kill_off_led",    int'(bus.led),    0);
      check("kill_off_busy",   int'(bus.busy),   0);
      check("kill_off_toggle", int'(bus.toggle), 0);
      bus.interval = 16'd2;
      step();
      check("restart_led", int'(bus.led), 1);
      repeat (7) step();
      bus.interval = 16'd0;
      step();
      check("kill_on_led",    int'(bus.led),    0);
      check("kill_on_busy",   int'(bus.busy),   0);
      check("kill_on_toggle", int'(bus.toggle), 1);
      step();
      bus.interval = 16'd2;
      step();
      check("iv2_led", int'(bus.led), 1);
      measure(1'b1, n);
      check("iv2_first_on", n, 20);

      // 5: one-tick phases, then a very long interval
      bus.interval = 16'd0;
      step();
      bus.interval = 16'd1;
      step();
      measure(1'b1, n);
      check("iv1_on", n, 10);
      measure(1'b0, n);
      check("iv1_off", n, 10);
      bus.interval = 16'd0;
      step();
      bus.interval = 16'hFFFF;
      step();
      repeat (2000) step();
      check("ivmax_led",  int'(bus.led),  1);
      check("ivmax_busy", int'(bus.busy), 1);

      // 6: reset pulse mid-OFF with interval 4 held
      bus.interval = 16'd0;
      step();
      bus.interval = 16'd4;
      step();
      measure(1'b1, n);
      check("iv4_on", n, 40);
      repeat (15) step();
      rst = 1'b1;
      step();
      check("rst_mid_led",    int'(bus.led),    0);
      check("rst_mid_busy",   int'(bus.busy),   0);
      check("rst_mid_toggle", int'(bus.toggle), 0);
      rst = 1'b0;
      step();
      check("post_rst_led",    int'(bus.led),    1);
      check("post_rst_toggle", int'(bus.toggle), 1);
      measure(1'b1, n);
      check("post_rst_on", n, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
